// File: rtl/dsi_clk_lane.sv
// dsi_clk_lane -- MIPI D-PHY clock lane sequencer.
//
// Drives the clock lane through the LP -> HS entry sequence
// (LP11, LP01, LP00, HS_ZERO, HS_PRE), holds the HS clock (HS_CLK), and
// returns through HS_POST and HS_TRAIL back to LP11. Each timed phase dwells
// cfg+1 cycles, with cfg sampled on phase entry.
//
// Optional feature: define DSI_CLK_ULPS_EN to add ultra-low-power state
// support (ULPS_ENTRY / ULPS / ULPS_WAKE plus ulps_req, cfg_wakeup and
// ulps_active ports). Without it those ports and states do not exist.
//
// Ports:
//   clk, rst        bit clock, synchronous active-high reset
//   hs_req          request HS clock
//   cfg_cont        continuous-clock mode (stay in HS_CLK)
//   cfg_lpx .. cfg_hs_trail   per-phase dwell settings (TW bits)
//   ulps_req, cfg_wakeup      ULPS request / wakeup dwell (DSI_CLK_ULPS_EN)
//   lp_p, lp_n      LP line levels
//   hs_oe, hs_bit   HS driver enable and P-side bit
//   hs_rdy          HS clock running
//   clk_sync        half-rate toggle shared with data lanes
//   ulps_active     lane in ULPS (DSI_CLK_ULPS_EN)
//   state_o         current FSM state (debug)
// All pin outputs are registered from the state of the previous cycle.

module dsi_clk_lane #(
    parameter int TW = 8,
    parameter int WW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hs_req,
    input  logic          cfg_cont,
    input  logic [TW-1:0] cfg_lpx,
    input  logic [TW-1:0] cfg_hs_prep,
    input  logic [TW-1:0] cfg_hs_zero,
    input  logic [TW-1:0] cfg_hs_pre,
    input  logic [TW-1:0] cfg_hs_post,
    input  logic [TW-1:0] cfg_hs_trail,
`ifdef DSI_CLK_ULPS_EN
    input  logic          ulps_req,
    input  logic [WW-1:0] cfg_wakeup,
    output logic          ulps_active,
`endif
    output logic          lp_p,
    output logic          lp_n,
    output logic          hs_oe,
    output logic          hs_bit,
    output logic          hs_rdy,
    output logic          clk_sync,
    output logic [3:0]    state_o
);

    typedef enum logic [3:0] {
        LP11       = 4'd0,
        LP01       = 4'd1,
        LP00       = 4'd2,
        HS_ZERO    = 4'd3,
        HS_PRE     = 4'd4,
        HS_CLK     = 4'd5,
        HS_POST    = 4'd6,
        HS_TRAIL   = 4'd7
`ifdef DSI_CLK_ULPS_EN
        ,
        ULPS_ENTRY = 4'd8,
        ULPS       = 4'd9,
        ULPS_WAKE  = 4'd10
`endif
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          trig;

    assign trig    = (timer == '0);
    assign state_o = state;

`ifdef DSI_CLK_ULPS_EN
    // Wakeup dwell is far longer than the HS phases, so it has its own timer.
    logic [WW-1:0] wake_tmr;
    logic          wake_trig;
    assign wake_trig = (wake_tmr == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LP11;
            timer    <= '0;
            clk_sync <= 1'b0;
            lp_p     <= 1'b1;
            lp_n     <= 1'b1;
            hs_oe    <= 1'b0;
            hs_bit   <= 1'b0;
            hs_rdy   <= 1'b0;
`ifdef DSI_CLK_ULPS_EN
            wake_tmr    <= '0;
            ulps_active <= 1'b0;
`endif
        end else begin
            clk_sync <= ~clk_sync;

            // Pin outputs decoded from the current state register.
            lp_p   <= (state == LP11);
            lp_n   <= (state == LP11) || (state == LP01);
            hs_oe  <= (state == HS_ZERO) || (state == HS_PRE) || (state == HS_CLK) ||
                      (state == HS_POST) || (state == HS_TRAIL);
            hs_bit <= clk_sync &&
                      ((state == HS_PRE) || (state == HS_CLK) || (state == HS_POST));
            hs_rdy <= (state == HS_CLK);
`ifdef DSI_CLK_ULPS_EN
            if ((state == ULPS_ENTRY) || (state == ULPS_WAKE))
                lp_p <= 1'b1;
            ulps_active <= (state == ULPS);
`endif

            case (state)
                LP11: begin
                    if (hs_req || cfg_cont) begin
                        state <= LP01;
                        timer <= cfg_lpx;
                    end
`ifdef DSI_CLK_ULPS_EN
                    else if (ulps_req) begin
                        state <= ULPS_ENTRY;
                        timer <= cfg_lpx;
                    end
`endif
                end
                LP01: begin
                    if (trig) begin
                        state <= LP00;
                        timer <= cfg_hs_prep;
                    end else
                        timer <= timer - 1'b1;
                end
                LP00: begin
                    if (trig) begin
                        state <= HS_ZERO;
                        timer <= cfg_hs_zero;
                    end else
                        timer <= timer - 1'b1;
                end
                HS_ZERO: begin
                    if (trig) begin
                        state <= HS_PRE;
                        timer <= cfg_hs_pre;
                    end else
                        timer <= timer - 1'b1;
                end
                HS_PRE: begin
                    if (trig)
                        state <= HS_CLK;
                    else
                        timer <= timer - 1'b1;
                end
                // Exit is only evaluated here, so a short hs_req pulse still
                // completes the full entry and gets at least one HS_CLK cycle.
                HS_CLK: begin
                    if (!hs_req && !cfg_cont) begin
                        state <= HS_POST;
                        timer <= cfg_hs_post;
                    end
                end
                HS_POST: begin
                    if (trig) begin
                        state <= HS_TRAIL;
                        timer <= cfg_hs_trail;
                    end else
                        timer <= timer - 1'b1;
                end
                HS_TRAIL: begin
                    if (trig)
                        state <= LP11;
                    else
                        timer <= timer - 1'b1;
                end
`ifdef DSI_CLK_ULPS_EN
                ULPS_ENTRY: begin
                    if (trig)
                        state <= ULPS;
                    else
                        timer <= timer - 1'b1;
                end
                ULPS: begin
                    if (!ulps_req) begin
                        state    <= ULPS_WAKE;
                        wake_tmr <= cfg_wakeup;
                    end
                end
                ULPS_WAKE: begin
                    if (wake_trig)
                        state <= LP11;
                    else
                        wake_tmr <= wake_tmr - 1'b1;
                end
`endif
                default: state <= LP11;
            endcase
        end
    end

endmodule
